// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP-1 controller-sequencer: six-state ring counter, instruction decoder and halt latch
module controller_sequencer #(
    parameter int NUM_T    = 6,
    parameter int OPCODE_W = 4
) (
    input  logic                CLK_bar,
    input  logic                CLR_bar,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                Cp,
    output logic                Ep,
    output logic                Lm_bar,
    output logic                CE_bar,
    output logic                Li_bar,
    output logic                Ei_bar,
    output logic                La_bar,
    output logic                Ea,
    output logic                Su,
    output logic                Eu,
    output logic                Lb_bar,
    output logic                Lo_bar,
    output logic                HLT,
    output logic [NUM_T-1:0]    t_state
);

    typedef enum logic [NUM_T-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_e;

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0000);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0001);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0010);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

    ring_e ring;
    logic  halt;

    assign t_state = ring;

    // Once halted the ring parks in T4; only CLR_bar releases it.
    always_ff @(posedge CLK_bar or negedge CLR_bar) begin
        if (!CLR_bar) begin
            ring <= T1;
            halt <= 1'b0;
        end else if (!halt) begin
            case (ring)
                T1: ring <= T2;
                T2: ring <= T3;
                T3: ring <= T4;
                T4: begin
                    if (opcode == OP_HLT) begin
                        halt <= 1'b1;
                    end else begin
                        ring <= T5;
                    end
                end
                T5:      ring <= T6;
                T6:      ring <= T1;
                default: ring <= T1;
            endcase
        end
    end

    // Decoder works in active-high terms; the *_bar pins are inverted at the end.
    logic lm, ce, li, ei, la, lb, lo;

    always_comb begin
        Cp = 1'b0;
        Ep = 1'b0;
        Ea = 1'b0;
        Su = 1'b0;
        Eu = 1'b0;
        lm = 1'b0;
        ce = 1'b0;
        li = 1'b0;
        ei = 1'b0;
        la = 1'b0;
        lb = 1'b0;
        lo = 1'b0;
        HLT = halt;
        case (ring)
            T1: begin
                Ep = 1'b1;
                lm = 1'b1;
            end
            T2: Cp = 1'b1;
            T3: begin
                ce = 1'b1;
                li = 1'b1;
            end
            T4: begin
                if (!halt) begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ei = 1'b1;
                            lm = 1'b1;
                        end
                        OP_OUT: begin
                            Ea = 1'b1;
                            lo = 1'b1;
                        end
                        OP_HLT:  HLT = 1'b1;
                        default: ;
                    endcase
                end
            end
            T5: begin
                case (opcode)
                    OP_LDA: begin
                        ce = 1'b1;
                        la = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ce = 1'b1;
                        lb = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    la = 1'b1;
                    Eu = 1'b1;
                    Su = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    assign Lm_bar = ~lm;
    assign CE_bar = ~ce;
    assign Li_bar = ~li;
    assign Ei_bar = ~ei;
    assign La_bar = ~la;
    assign Lb_bar = ~lb;
    assign Lo_bar = ~lo;

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- SAP-1 controller-sequencer: six-state ring counter (T1..T6) plus instruction decoder.
- Generates the 12-bit control word that drives the program counter (Cp, Ep), MAR, RAM, IR, accumulator, adder/subtractor, B and output registers.
- It is the initiator side of the control interface: the program counter and the other bus agents only respond to these signals.
- Latches the HLT condition and freezes the ring counter until reset.

Parameters:
- NUM_T, 6, number of ring-counter T-states; fixed at 6 for SAP-1.
- OPCODE_W, 4, width of the opcode field from the instruction register upper nibble.

Ports:
- CLK_bar  input  1  system clock; state advances on rising edge of CLK_bar.
- CLR_bar  input  1  asynchronous, active-low reset.
- opcode  input  OPCODE_W  IR upper nibble; valid and stable from T4 through T6.
- Cp  output  1  PC increment, active-high.
- Ep  output  1  PC drive W bus, active-high.
- Lm_bar  output  1  MAR load, active-low.
- CE_bar  output  1  RAM drive W bus, active-low.
- Li_bar  output  1  IR load, active-low.
- Ei_bar  output  1  IR drive W bus (address nibble), active-low.
- La_bar  output  1  accumulator load, active-low.
- Ea  output  1  accumulator drive W bus, active-high.
- Su  output  1  adder/subtractor mode; 1 = subtract.
- Eu  output  1  adder/subtractor drive W bus, active-high.
- Lb_bar  output  1  B register load, active-low.
- Lo_bar  output  1  output register load, active-low.
- HLT  output  1  halt indicator, active-high.
- t_state  output  NUM_T  one-hot ring state; bit0 = T1.

Behaviour:
- Reset (CLR_bar=0): asynchronous and immediate, no clock edge needed. t_state=000001 (T1), halt latch=0.
- Outputs are combinational from t_state, opcode and the halt latch. During and just after reset they show the T1 word.
- Idle word: Cp=Ep=Ea=Su=Eu=HLT=0; all *_bar=1. Any signal not listed below for a state takes its idle value.
- Ring: each CLK_bar rising edge advances T1→T2→…→T6→T1 while halt=0. If t_state is not one-hot, it goes to T1 on the next edge.
- Fetch cycle, independent of opcode:
  - T1: Ep=1, Lm_bar=0.
  - T2: Cp=1.
  - T3: CE_bar=0, Li_bar=0.
- Execute cycle:
  - LDA (0000):
    - T4: Ei_bar=0, Lm_bar=0.
    - T5: CE_bar=0, La_bar=0.
    - T6: idle.
  - ADD (0001):
    - T4: Ei_bar=0, Lm_bar=0.
    - T5: CE_bar=0, Lb_bar=0.
    - T6: La_bar=0, Eu=1, Su=0.
  - SUB (0010): same as ADD, except Su=1 in T6. Su=0 in every other state and for every other opcode.
  - OUT (1110):
    - T4: Ea=1, Lo_bar=0.
    - T5, T6: idle.
  - HLT (1111):
    - T4: HLT=1 combinationally.
    - At the next edge the halt latch sets. t_state then stays at 001000 (T4) indefinitely, HLT=1, all other controls idle.
    - Only CLR_bar clears the halt latch.
  - Any other opcode: NOP; T4–T6 idle, ring continues.
- Bus exclusivity invariant: at most one of Ep, CE_bar=0, Ei_bar=0, Ea, Eu is active in any state.
- Opcode changes during T1–T3 have no effect on outputs.
- Opcode is never registered here; the IR holds it.

Test Plan:
- Reset: CLR_bar=0 with no clock → t_state=000001, Ep=1, Lm_bar=0, all others idle, HLT=0.
- Fetch: release reset, opcode=0101, 3 edges → T2 shows Cp=1 only; T3 shows CE_bar=0 and Li_bar=0; T4–T6 idle; wrap to t_state=000001 on the 6th edge.
- LDA: opcode=0000 → T4 Ei_bar=0, Lm_bar=0; T5 CE_bar=0, La_bar=0; T6 idle; bus-exclusivity check every cycle.
- ADD vs SUB: opcode=0001 → T5 Lb_bar=0; T6 La_bar=0, Eu=1, Su=0. Repeat with opcode=0010 → T6 Su=1. Su=0 in all other states.
- HLT and OUT: opcode=1110 → T4 Ea=1, Lo_bar=0. Then opcode=1111 → T4 HLT=1; after 10 more edges t_state=001000, HLT=1, controls idle. CLR_bar pulse → T1, HLT=0.
- Async reset mid-execute: ADD in T5, assert CLR_bar between edges → t_state=000001 immediately, Lb_bar=1, Ep=1.
